// File: rtl/nco_pkg.sv
// Shared widths, FSM state type and phase-increment helper for the PLL NCO.
package nco_pkg;

  localparam int unsigned PHASE_W = 32;
  localparam int unsigned F_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    PEND
  } state_t;

  // floor(f * 2^32 / clk_hz): phase increment for a requested frequency
  function automatic logic [PHASE_W-1:0] inc_of(input logic [F_W-1:0] f,
                                                input logic [F_W-1:0] clk_hz);
    logic [63:0] num;
    num = {f, 32'd0};
    return PHASE_W'(num / {32'd0, clk_hz});
  endfunction

endpackage

// File: rtl/nco_vco_div_seq.sv
// 32-iteration restoring divider: quotient = floor(dividend_hi * 2^32 / divisor).
// Requires dividend_hi < divisor so the quotient fits in 32 bits.
module nco_div_seq
  import nco_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [F_W-1:0]     dividend_hi,
  input  logic [F_W-1:0]     divisor,
  output logic [PHASE_W-1:0] quotient,
  output logic               done
);

  localparam int unsigned CNT_W = 6;

  logic [F_W-1:0]   rem;
  logic [F_W:0]     rem2;
  logic [F_W-1:0]   rem_nx;
  logic             q_bit;
  logic [CNT_W-1:0] cnt;
  logic             run;

  // one restoring step on the shifted remainder
  always_comb begin
    rem2   = {rem, 1'b0};
    q_bit  = (rem2 >= {1'b0, divisor});
    rem_nx = q_bit ? F_W'(rem2 - {1'b0, divisor}) : rem2[F_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= dividend_hi;
        quotient <= '0;
        cnt      <= '0;
        run      <= 1'b1;
      end else if (run) begin
        rem      <= rem_nx;
        quotient <= {quotient[PHASE_W-2:0], q_bit};
        cnt      <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(PHASE_W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nco_vco.sv
// Phase-accumulator NCO producing the PLL feedback square wave; frequency updates
// land only on period starts. Optional VCO_SYNC_EN adds a `sync` forced-restart input.
module nco_vco
  import nco_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned F_RESET = 40000,
  parameter int unsigned F_MIN   = 20000,
  parameter int unsigned F_MAX   = 80000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alive,
`ifdef VCO_SYNC_EN
  input  logic           sync,
`endif
  input  logic [F_W-1:0] f_in,
  input  logic           f_valid,
  output logic           f_ready,
  output logic           vco,
  output logic           vco_rise,
  output logic [F_W-1:0] f_active,
  output logic           clamped,
  output logic           busy
);

  localparam logic [PHASE_W-1:0] INC_RESET = inc_of(F_W'(F_RESET), F_W'(CLK_HZ));

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W:0]   sum;
  logic               carry;
  logic               run;
  logic               sync_hit;
  logic               period_start;
  logic               transfer;
  logic               clip;
  logic [F_W-1:0]     fc_in;
  logic [F_W-1:0]     fc;
  logic               pend_now;
  logic               apply;
  logic [PHASE_W-1:0] div_q;
  logic               div_done;
  state_t             state;
  state_t             state_nx;

  nco_div_seq u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (transfer),
    .dividend_hi (fc_in),
    .divisor     (F_W'(CLK_HZ)),
    .quotient    (div_q),
    .done        (div_done)
  );

  // The cycle the divider reports done already counts as pending, so a wrap there applies.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, inc};
    carry = sum[PHASE_W];
`ifdef VCO_SYNC_EN
    sync_hit = alive & sync;
`else
    sync_hit = 1'b0;
`endif
    period_start = alive & (carry | ~run | sync_hit);
    transfer     = f_valid & f_ready;
    clip         = (f_in < F_W'(F_MIN)) | (f_in > F_W'(F_MAX));
    if (f_in < F_W'(F_MIN))      fc_in = F_W'(F_MIN);
    else if (f_in > F_W'(F_MAX)) fc_in = F_W'(F_MAX);
    else                         fc_in = f_in;
    pend_now = (state == PEND) | ((state == DIV) & div_done);
    apply    = pend_now & (~alive | period_start);
    state_nx = state;
    case (state)
      IDLE:    if (transfer) state_nx = DIV;
      DIV:     if (div_done) state_nx = apply ? IDLE : PEND;
      PEND:    if (apply)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      inc      <= INC_RESET;
      vco      <= 1'b1;
      vco_rise <= 1'b0;
      f_active <= F_W'(F_RESET);
      fc       <= F_W'(F_RESET);
      clamped  <= 1'b0;
      f_ready  <= 1'b1;
      busy     <= 1'b0;
      run      <= 1'b1;
      state    <= IDLE;
    end else begin
      state   <= state_nx;
      f_ready <= (state_nx == IDLE);
      busy    <= (state_nx != IDLE);
      run     <= alive;
      if (!alive) begin
        acc      <= '0;
        vco      <= 1'b0;
        vco_rise <= 1'b0;
      end else if (sync_hit) begin
        acc      <= '0;
        vco      <= 1'b1;
        vco_rise <= 1'b1;
      end else begin
        acc      <= sum[PHASE_W-1:0];
        vco      <= ~sum[PHASE_W-1];
        vco_rise <= period_start;
      end
      if (transfer) begin
        fc      <= fc_in;
        clamped <= clip;
      end
      // new increment takes effect the cycle after the wrap that applies it
      if (apply) begin
        inc      <= div_q;
        f_active <= fc;
      end
    end
  end

endmodule

// File: tb/tb_nco_vco.sv
// Directed self-checking bench for nco_vco at CLK_HZ=1e8 (periods, clamping, update timing).
module tb_nco_vco;

  logic        clk;
  logic        rst;
  logic        alive;
  logic [31:0] f_in;
  logic        f_valid;
  logic        f_ready;
  logic        vco;
  logic        vco_rise;
  logic [31:0] f_active;
  logic        clamped;
  logic        busy;
`ifdef VCO_SYNC_EN
  logic        sync;
`endif

  int n_checks = 0;
  int n_errors = 0;

  nco_vco dut (
    .clk      (clk),
    .rst      (rst),
    .alive    (alive),
`ifdef VCO_SYNC_EN
    .sync     (sync),
`endif
    .f_in     (f_in),
    .f_valid  (f_valid),
    .f_ready  (f_ready),
    .vco      (vco),
    .vco_rise (vco_rise),
    .f_active (f_active),
    .clamped  (clamped),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shortest high phase seen while mon_en is set
  bit mon_en = 1'b0;
  int hi_run = 0;
  int min_hi = 99999;
  bit prev_vco = 1'b0;
  always @(negedge clk) begin
    if (!mon_en) min_hi = 99999;
    if (vco_rise) hi_run = 1;
    else if (vco) hi_run = hi_run + 1;
    else if (prev_vco && mon_en && hi_run < min_hi) min_hi = hi_run;
    prev_vco = vco;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(input string tag);
    int n;
    @(negedge clk);
    n = 1;
    while (!vco_rise && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rise_seen"}, 32'(vco_rise), 1);
  endtask

  task automatic measure(input string tag, input int plo, input int phi,
                         input int hlo, input int hhi);
    int per;
    int hi;
    wait_rise(tag);
    per = 0;
    hi  = 1;
    do begin
      @(negedge clk);
      per++;
      if (vco && !vco_rise) hi++;
    end while (!vco_rise && per < 8000);
    $display("info %s: period %0d cycles, high %0d cycles", tag, per, hi);
    check({tag, "_period"}, 32'(per >= plo && per <= phi), 1);
    check({tag, "_high"},   32'(hi >= hlo && hi <= hhi), 1);
  endtask

  task automatic send(input logic [31:0] f);
    int n = 0;
    while (!f_ready && n < 12000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(f_ready), 1);
    f_in    = f;
    f_valid = 1'b1;
    @(negedge clk);
    f_valid = 1'b0;
  endtask

  task automatic wait_apply(input string tag, input logic [31:0] f);
    int n = 0;
    while (f_active !== f && n < 12000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_applied"}, 32'(f_active === f), 1);
    check({tag, "_on_wrap"}, 32'(vco_rise), 1);
    check({tag, "_busy"},    32'(busy), 0);
  endtask

  initial begin
    int  n;
    bit  found;
    bit  early;
    rst     = 1'b1;
    alive   = 1'b1;
    f_in    = '0;
    f_valid = 1'b0;
`ifdef VCO_SYNC_EN
    sync    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_vco",      32'(vco), 1);
    check("rst_rise",     32'(vco_rise), 0);
    check("rst_f_active", f_active, 40000);
    check("rst_clamped",  32'(clamped), 0);
    check("rst_f_ready",  32'(f_ready), 1);
    check("rst_busy",     32'(busy), 0);
    rst = 1'b0;

    // 40 kHz out of reset: inc 1717986 -> 2500/2501 cycle period
    measure("f40k", 2500, 2501, 1249, 1252);

    // 45 kHz: update lands on the first wrap at least 33 cycles after the transfer
    send(45000);
    check("f45k_ready_low", 32'(f_ready), 0);
    check("f45k_busy",      32'(busy), 1);
    check("f45k_clamped",   32'(clamped), 0);
    n = 1; found = 1'b0; early = 1'b0;
    while (!found && n < 6000) begin
      @(negedge clk);
      n++;
      if (vco_rise && n >= 34) found = 1'b1;
      else if (f_active !== 32'd40000) early = 1'b1;
    end
    check("f45k_wrap_found", 32'(found), 1);
    check("f45k_no_early",   32'(early), 0);
    check("f45k_f_active",   f_active, 45000);
    check("f45k_busy_done",  32'(busy), 0);
    check("f45k_ready_back", 32'(f_ready), 1);
    measure("f45k", 2222, 2223, 1110, 1113);

    // clamping above and below, then back in range
    send(100000);
    check("f100k_clamped", 32'(clamped), 1);
    wait_apply("f80k", 80000);
    measure("f80k", 1250, 1251, 624, 627);
    send(10000);
    check("f10k_clamped", 32'(clamped), 1);
    wait_apply("f20k", 20000);
    send(30000);
    check("f30k_clamped", 32'(clamped), 0);
    wait_apply("f30k", 30000);
    measure("f30k", 3333, 3334, 1665, 1668);

    // f_valid held through DIV/PEND with a changed f_in
    wait_rise("hold");
    mon_en  = 1'b1;
    f_in    = 50000;
    f_valid = 1'b1;
    @(negedge clk);
    f_in = 60000;
    check("hold_ready_low", 32'(f_ready), 0);
    n = 0;
    while (f_active === 32'd30000 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check("hold_first_value", f_active, 50000);
    check("hold_ready_idle",  32'(f_ready), 1);
    @(negedge clk);
    check("hold_second_xfer", 32'(busy), 1);
    f_valid = 1'b0;
    wait_apply("f60k", 60000);
    measure("f60k", 1666, 1667, 832, 835);
    check("hold_min_high_ok", 32'(min_hi >= 832), 1);
    mon_en = 1'b0;

    // alive dropped while the update is pending
    wait_rise("alive");
    send(45000);
    repeat (40) @(negedge clk);
    check("alive_pending", 32'(busy), 1);
    alive = 1'b0;
    @(negedge clk);
    check("alive_applied",  f_active, 45000);
    check("alive_vco_low",  32'(vco), 0);
    check("alive_busy",     32'(busy), 0);
    check("alive_no_rise",  32'(vco_rise), 0);
    repeat (5) @(negedge clk);
    check("alive_held_low", 32'(vco), 0);
    alive = 1'b1;
    @(negedge clk);
    check("restart_vco",  32'(vco), 1);
    check("restart_rise", 32'(vco_rise), 1);
    @(negedge clk);
    check("restart_rise_once", 32'(vco_rise), 0);
    measure("restart", 2222, 2223, 1110, 1113);

    // reset in the middle of a divide
    send(80000);
    repeat (10) @(negedge clk);
    check("middiv_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("middiv_f_active", f_active, 40000);
    check("middiv_f_ready",  32'(f_ready), 1);
    check("middiv_busy_clr", 32'(busy), 0);
    check("middiv_vco",      32'(vco), 1);
    measure("middiv", 2500, 2501, 1249, 1252);
    check("middiv_no_apply", f_active, 40000);

`ifdef VCO_SYNC_EN
    // forced period start mid-period
    wait_rise("sync");
    repeat (500) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync_rise", 32'(vco_rise), 1);
    check("sync_vco",  32'(vco), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vco_rise && n < 8000);
    check("sync_next_period", 32'(n >= 2500 && n <= 2501), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nco_vco.md
Name: nco_vco

Overview:
- Numerically controlled oscillator that acts as the consumer of the PLL's 32-bit frequency word `f` (Hz).
- Produces the digital `vco` square wave fed back to the PFD.
- Frequency updates arrive over a valid/ready handshake, are clamped, and are converted to a phase increment by a sequential divider.
- Each update is applied only at a period boundary, so no `vco` pulse is ever truncated.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- F_RESET, 40000, frequency applied out of reset (Hz).
- F_MIN, 20000, lower clamp bound (Hz).
- F_MAX, 80000, upper clamp bound (Hz); must be < CLK_HZ/2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- alive  in  1  oscillator run enable (SWIPT link alive).
- f_in  in  32  requested frequency, Hz.
- f_valid  in  1  `f_in` valid.
- f_ready  out  1  block can accept a new `f_in`.
- vco  out  1  oscillator output; high for the first half of each period.
- vco_rise  out  1  one-cycle pulse on every period start.
- f_active  out  32  frequency currently in effect (post-clamp).
- clamped  out  1  sticky; set when an accepted `f_in` was clamped, cleared on the next unclamped accept.
- busy  out  1  update in progress (DIV or PEND).

Behaviour:
- Reset (rst=1 at clk edge):
  - acc=0, inc=INC_RESET, where INC_RESET = floor(F_RESET*2^32/CLK_HZ), computed as an elaboration-time constant.
  - vco=1, vco_rise=0, f_active=F_RESET, clamped=0, f_ready=1, busy=0, state=IDLE.
  - Reset mid-operation aborts any divide or pending update.
- Phase accumulator:
  - 32-bit acc; each cycle with alive=1, {carry,acc} <= acc + inc.
  - vco = ~acc[31], registered.
  - carry=1 marks a wrap (period start): vco_rise=1 for exactly that cycle.
- alive=0: acc held at 0, vco=0, vco_rise=0.
  - On the first cycle with alive=1 again, vco=1 and vco_rise=1; a fresh period starts.
- Handshake: transfer occurs when f_valid && f_ready. f_ready=1 only in IDLE. f_in is sampled on the transfer cycle.
- Clamp: fc = min(max(f_in,F_MIN),F_MAX). clamped updated on every transfer.
- States:
  - IDLE: on transfer → DIV; latch fc; load rem=fc, q=0, cnt=0.
  - DIV: 32 restoring-division iterations, one per cycle:
    - rem2 = rem<<1;
    - if rem2>=CLK_HZ then rem=rem2-CLK_HZ and the q bit = 1, else rem=rem2 and the q bit = 0;
    - q shifts left, taking the new bit as its LSB.
    - After the 32nd iteration → PEND; result q = floor(fc*2^32/CLK_HZ).
  - PEND: on the next wrap cycle (carry=1), inc <= q and f_active <= fc, then → IDLE.
    - The addition producing that wrap uses the old inc; the new inc is effective from the following cycle.
    - If alive=0 in PEND, apply immediately on that cycle.
- Latency: transfer at cycle T → q ready at T+32 → applied at the first wrap at or after T+33. busy=1 from T+1 until the apply cycle inclusive.
- f_valid held while not ready: no transfer; the input is ignored until IDLE.
- Arithmetic:
  - All unsigned.
  - The divider remainder is 33 bits wide to hold rem<<1.
  - Since fc<CLK_HZ, the quotient fits in 32 bits.
- Period = ceil(2^32/inc) or floor(2^32/inc) cycles; duty cycle is 50% ±1 cycle.

Optional Feature:
- Macro: VCO_SYNC_EN.
- Defined: extra input port `sync` (1 bit).
  - When sync=1 with alive=1, acc <= 0 next cycle, vco=1, and vco_rise=1 (a forced period start). The carry from that cycle is discarded.
  - A sync cycle counts as a wrap for PEND apply.
  - sync has priority over the normal increment.
- Undefined: no `sync` port; phase advances only by accumulation.

Decomposition:
- Package nco_pkg:
  - PHASE_W=32, F_W=32.
  - state enum {IDLE, DIV, PEND}.
  - Constant function inc_of(f, clk_hz), used for INC_RESET and by the bench model.
- One sub-module, nco_div_seq: 32-cycle restoring divider.
  - Ports: clk, rst, start, dividend_hi (32), divisor (const), quotient (32), done.
  - nco_vco instantiates it and sequences it from DIV.

Test Plan:
- Reset, CLK_HZ=1e8, alive=1 → vco=1 after reset, f_active=40000, inc=1717986; vco_rise period 2500 cycles (±1), high phase 1250±1.
- f_in=45000 accepted at T → f_ready=0 from T+1; q=1932735 at T+32; applied on the first wrap ≥ T+33; subsequent period 2222/2223 cycles; f_active=45000; clamped=0.
- f_in=100000 → f_active=80000, inc=3435973, clamped=1, period 1250±1; then f_in=10000 → f_active=20000, clamped=1; then f_in=30000 → clamped=0.
- f_valid held high during DIV/PEND with changing f_in → only the first value transfers; the second transfers on the first IDLE cycle; no truncated vco pulse (every high phase ≥ half the old or new period −1).
- alive dropped in PEND → update applied that cycle, vco=0; alive restored → vco=1, vco_rise=1 on the first cycle.
- rst asserted mid-DIV → state IDLE, inc=1717986, f_active=40000, f_ready=1 next cycle. With VCO_SYNC_EN: sync pulse mid-period → vco_rise next cycle, acc=0.
